// File: rtl/period_freq_meter.sv
// period_freq_meter
//   Reciprocal frequency meter. Counts reference-clock ticks over 2^AVG_LOG2
//   periods of the asynchronous input cin, divides (K << AVG_LOG2) by that
//   count with a 1 bit/cycle restoring divider, converts the quotient to BCD
//   with a 1 bit/cycle double-dabble and presents it on data with a valid
//   pulse.
//
//   Optional feature macro: PFM_TIMEOUT_EN
//     defined   : a period count reaching 2^CNT_W-1 ends the measurement with
//                 data=0, ovf=0, tmo=1; port tmo exists.
//     undefined : the period counter saturates and the meter waits for a rise.
//
//   Ports
//     clk    in   reference clock, all logic rising-edge
//     Rst    in   asynchronous active-high reset
//     cin    in   measured signal, asynchronous to clk
//     data   out  4*DIGITS BCD result, digit 0 in data[3:0]
//     valid  out  one-cycle pulse when data updates
//     busy   out  high while dividing or converting
//     ovf    out  result saturated to all nines
//     tmo    out  measurement timed out (PFM_TIMEOUT_EN only)
module period_freq_meter #(
   parameter int CNT_W    = 24,
   parameter int Q_W      = 24,
   parameter int DIGITS   = 6,
   parameter int K        = 25000,
   parameter int AVG_LOG2 = 0
) (
   input  logic                clk,
   input  logic                Rst,
   input  logic                cin,
   output logic [4*DIGITS-1:0] data,
   output logic                valid,
   output logic                busy,
   output logic                ovf
`ifdef PFM_TIMEOUT_EN
   ,
   output logic                tmo
`endif
);

   function automatic logic [63:0] f_pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   function automatic logic [4*DIGITS-1:0] f_all9();
      logic [4*DIGITS-1:0] v;
      v = '0;
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'd9;
      return v;
   endfunction

   // Double-dabble correction: any digit >= 5 gets +3 before the shift.
   function automatic logic [4*DIGITS-1:0] f_dabble(input logic [4*DIGITS-1:0] b);
      logic [4*DIGITS-1:0] v;
      v = b;
      for (int i = 0; i < DIGITS; i++)
         if (b[4*i +: 4] >= 4'd5) v[4*i +: 4] = b[4*i +: 4] + 4'd3;
      return v;
   endfunction

   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
   localparam logic [Q_W-1:0]      NUM      = Q_W'(longint'(K) << AVG_LOG2);
   localparam logic [AVG_LOG2:0]   EDGE_TGT = (AVG_LOG2+1)'(64'd1 << AVG_LOG2);
   localparam int                  STEP_W   = $clog2(Q_W);
   localparam logic [STEP_W-1:0]   STEP_END = STEP_W'(Q_W-1);
   localparam logic [63:0]         DEC_LIM  = f_pow10(DIGITS);
   localparam logic [4*DIGITS-1:0] ALL9     = f_all9();

   generate
      if ((64'(K) << AVG_LOG2) >= (64'd1 << Q_W)) begin : g_num_chk
         $error("period_freq_meter: K << AVG_LOG2 does not fit in Q_W bits");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DIV, S_BCD, S_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic                r_sync1, r_sync2, r_sync3;
   logic [CNT_W-1:0]    r_cnt, r_den, r_rem;
   logic [AVG_LOG2:0]   r_edges;
   logic [Q_W-1:0]      r_quo;
   logic [STEP_W-1:0]   r_step;
   logic [4*DIGITS-1:0] r_bcd, r_data;
   logic                r_ovf_q, r_ovf, r_valid;
`ifdef PFM_TIMEOUT_EN
   logic                r_tmo;
`endif

   logic                w_rise, w_close, w_step_last, w_tmo_hit, w_ge;
   logic [CNT_W-1:0]    w_cnt_inc, w_sub, w_rem_nxt;
   logic [AVG_LOG2:0]   w_edges_inc;
   logic [CNT_W:0]      w_shift;
   logic [Q_W-1:0]      w_quo_step, w_quo_fin;
   logic [4*DIGITS-1:0] w_dab, w_bcd_step;

   assign w_rise      = r_sync2 & ~r_sync3;
   assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
   assign w_edges_inc = r_edges + 1'b1;
   // The closing rise's cycle is included in the latched count.
   assign w_close     = (r_state == S_COUNT) && w_rise && (w_edges_inc == EDGE_TGT);
   assign w_step_last = (r_step == STEP_END);
`ifdef PFM_TIMEOUT_EN
   assign w_tmo_hit   = (r_state == S_COUNT) && !w_close && (r_cnt == CNT_MAX);
`else
   assign w_tmo_hit   = 1'b0;
`endif

   // Restoring divider step: numerator bits shift out of r_quo MSB-first,
   // quotient bits shift in at the LSB.
   assign w_shift    = {r_rem, r_quo[Q_W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_den});
   assign w_sub      = CNT_W'(w_shift - {1'b0, r_den});
   assign w_rem_nxt  = w_ge ? w_sub : w_shift[CNT_W-1:0];
   assign w_quo_step = {r_quo[Q_W-2:0], w_ge};
   assign w_quo_fin  = (r_den == '0) ? '1 : w_quo_step;

   assign w_dab      = f_dabble(r_bcd);
   assign w_bcd_step = {w_dab[4*DIGITS-2:0], r_quo[Q_W-1]};

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_rise) w_state_nxt = S_COUNT;
         S_COUNT: begin
            if (w_close)        w_state_nxt = S_DIV;
            else if (w_tmo_hit) w_state_nxt = S_DONE;
         end
         S_DIV:   if (w_step_last) w_state_nxt = S_BCD;
         S_BCD:   if (w_step_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_cnt   <= '0;
         r_edges <= '0;
         r_den   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_step  <= '0;
         r_bcd   <= '0;
         r_ovf_q <= 1'b0;
         r_data  <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
`ifdef PFM_TIMEOUT_EN
         r_tmo   <= 1'b0;
`endif
      end else begin
         r_sync1 <= cin;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_cnt   <= '0;
                  r_edges <= '0;
               end
            end
            S_COUNT: begin
               r_cnt <= w_cnt_inc;
               if (w_rise) r_edges <= w_edges_inc;
               if (w_close) begin
                  r_den  <= w_cnt_inc;
                  r_rem  <= '0;
                  r_quo  <= NUM;
                  r_step <= '0;
               end else if (w_tmo_hit) begin
                  r_data  <= '0;
                  r_ovf   <= 1'b0;
                  r_valid <= 1'b1;
`ifdef PFM_TIMEOUT_EN
                  r_tmo   <= 1'b1;
`endif
               end
            end
            S_DIV: begin
               r_rem  <= w_rem_nxt;
               r_step <= r_step + 1'b1;
               if (w_step_last) begin
                  r_quo   <= w_quo_fin;
                  r_ovf_q <= (64'(w_quo_fin) >= DEC_LIM);
                  r_bcd   <= '0;
                  r_step  <= '0;
               end else begin
                  r_quo <= w_quo_step;
               end
            end
            S_BCD: begin
               r_bcd  <= w_bcd_step;
               r_quo  <= {r_quo[Q_W-2:0], 1'b0};
               r_step <= r_step + 1'b1;
               if (w_step_last) begin
                  r_step  <= '0;
                  r_data  <= r_ovf_q ? ALL9 : w_bcd_step;
                  r_ovf   <= r_ovf_q;
                  r_valid <= 1'b1;
`ifdef PFM_TIMEOUT_EN
                  r_tmo   <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign data  = r_data;
   assign valid = r_valid;
   assign ovf   = r_ovf;
   assign busy  = (r_state == S_DIV) || (r_state == S_BCD);
`ifdef PFM_TIMEOUT_EN
   assign tmo   = r_tmo;
`endif

endmodule
